timer_dev: RTL



---
 rtl/timer_dev.sv | 126 ++++++++++++
 1 files changed

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer with CTRL/PRESET/COUNT registers and a maskable interrupt.
// Define TIMER_PRESCALE_EN to divide the count rate by PRESCALE core cycles.
module timer_dev #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CNT,
        S_INT
    } state_t;

    state_t      r_state;
    logic [3:0]  r_ctrl;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_flag;

    logic        w_wr_ctrl;
    logic        w_wr_preset;
    logic        w_tick;
    logic        w_unused;

    assign w_wr_ctrl   = we && (addr[1:0] == 2'd0);
    assign w_wr_preset = we && (addr[1:0] == 2'd1);

`ifdef TIMER_PRESCALE_EN
    localparam logic [15:0] LP_PRE_LAST = 16'(PRESCALE - 1);

    logic [15:0] r_pre;

    assign w_tick   = (r_pre == LP_PRE_LAST);
    assign w_unused = ^addr[29:2];

    // Prescaler only advances while counting; any other state parks it at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre <= 16'd0;
        end else if (r_state == S_CNT) begin
            r_pre <= w_tick ? 16'd0 : r_pre + 16'd1;
        end else begin
            r_pre <= 16'd0;
        end
    end
`else
    assign w_tick   = 1'b1;
    assign w_unused = ^addr[29:2] ^ (PRESCALE == 0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_ctrl   <= 4'd0;
            r_preset <= 32'd0;
            r_count  <= 32'd0;
            r_flag   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_ctrl[0]) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_count <= r_preset;
                    r_flag  <= 1'b0;
                    r_state <= S_CNT;
                end
                S_CNT: begin
                    if (!r_ctrl[0]) begin
                        r_state <= S_IDLE;
                    end else if (w_tick) begin
                        if (r_count > 32'd1) begin
                            r_count <= r_count - 32'd1;
                        end else begin
                            r_count <= 32'd0;
                            r_state <= S_INT;
                        end
                    end
                end
                S_INT: begin
                    r_flag <= 1'b1;
                    if (r_ctrl[2:1] == 2'b01) begin
                        r_state <= S_LOAD;
                    end else begin
                        r_ctrl[0] <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // NOTE: non-blocking assignments let the later bus write override the FSM's
            // update of CTRL and the irq flag in the same cycle (last NBA wins).
            if (w_wr_ctrl) begin
                r_ctrl <= din[3:0];
                r_flag <= 1'b0;
            end
            if (w_wr_preset) begin
                r_preset <= din;
            end
        end
    end

    always_comb begin
        dout = 32'd0;
        case (addr[1:0])
            2'd0:    dout = {28'd0, r_ctrl};
            2'd1:    dout = r_preset;
            2'd2:    dout = r_count;
            default: dout = 32'd0;
        endcase
    end

    assign irq = r_flag & r_ctrl[3];

endmodule
